// File: rtl/gba_keypad.sv
// Keypad front end: synchronizes and debounces the SNES button vector, remaps it to the
// GBA KEYINPUT layout, holds KEYCNT and raises a one-cycle keypad interrupt request.
module gba_keypad #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] buttons_raw,
    input  logic [15:0] keycnt_wdata,
    input  logic        keycnt_we,
    output logic [15:0] keyinput,
    output logic [15:0] keycnt,
    output logic        key_irq
);

    localparam int               CNT_W       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [15:0]      KEYCNT_MASK = 16'hC3FF;

    logic [SYNC_STAGES-1:0][15:0] sync_ff;
    logic [15:0]                  sync;
    logic [15:0]                  cand;
    logic [15:0]                  stable;
    logic [CNT_W-1:0]             cnt;
    logic [9:0]                   pressed;
    logic [9:0]                   sel;
    logic                         en;
    logic                         mode;
    logic                         cond;
    logic                         cond_q;
    logic                         unused_bits;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff[0] <= buttons_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    // Whole-vector debounce: any difference restarts the count, so a change must be
    // seen unchanged for STABLE_CYCLES samples before it reaches stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else if (sync != cand) begin
            cand <= sync;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            stable <= cand;
        end
    end

    // GBA order: A, B, Select, Start, Right, Left, Up, Down, R, L.
    assign pressed = {stable[10], stable[11], stable[5], stable[4], stable[6],
                      stable[7],  stable[3],  stable[2], stable[0], stable[8]};

    assign keyinput = {6'b0, ~pressed};

    // SNES Y, X and the unused top nibble take part in debouncing only.
    assign unused_bits = ^{stable[15:12], stable[9], stable[1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            keycnt <= '0;
        end else if (keycnt_we) begin
            keycnt <= keycnt_wdata & KEYCNT_MASK;
        end
    end

    assign sel  = keycnt[9:0];
    assign en   = keycnt[14];
    assign mode = keycnt[15];

    assign cond = en & (mode ? ((sel != '0) && ((pressed & sel) == sel))
                             : (|(pressed & sel)));

    always_ff @(posedge clock) begin
        if (reset) begin
            cond_q <= 1'b0;
        end else begin
            cond_q <= cond;
        end
    end

    assign key_irq = cond & ~cond_q;

endmodule

// File: tb/tb_gba_keypad.sv
// Bench for gba_keypad: hand-written latency/IRQ/reset sequences plus a table of
// stimulus steps, with expected outputs queued at drive time and popped at sampling.
module tb_gba_keypad;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 16;
    localparam int LAT           = SYNC_STAGES + STABLE_CYCLES;
    localparam int L4            = LAT + 4;
    localparam int N_STEPS       = 22;

    typedef struct {
        logic [15:0] btn;
        logic        we;
        logic [15:0] wdata;
        int          cycles;
        logic [15:0] exp_ki;
        logic [15:0] exp_kc;
        int          exp_irqs;
    } step_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] buttons_raw;
    logic [15:0] keycnt_wdata;
    logic        keycnt_we;
    logic [15:0] keyinput;
    logic [15:0] keycnt;
    logic        key_irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];
    step_t steps [0:N_STEPS-1];

    always #5 clk = ~clk;

    gba_keypad #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .buttons_raw (buttons_raw),
        .keycnt_wdata(keycnt_wdata),
        .keycnt_we   (keycnt_we),
        .keyinput    (keyinput),
        .keycnt      (keycnt),
        .key_irq     (key_irq)
    );

    // One active edge, then return at the following falling edge: outputs are
    // sampled and new inputs driven there.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [15:0] ki, input logic [15:0] kc, input logic irq);
        exp_q.push_back({ki, kc, irq});
    endtask

    task automatic compare_out(input string name);
        logic [32:0] e;
        logic [32:0] a;
        a = {keyinput, keycnt, key_irq};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got keyinput=%h keycnt=%h key_irq=%b, required keyinput=%h keycnt=%h key_irq=%b",
                         name, a[32:17], a[16:1], a[0], e[32:17], e[16:1], e[0]);
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int irqs;

        steps[0]  = '{16'h0000, 1'b1, 16'h4001, 2,  16'h03FF, 16'h4001, 0};
        steps[1]  = '{16'h0100, 1'b0, 16'h0000, L4, 16'h03FE, 16'h4001, 1};
        steps[2]  = '{16'h0100, 1'b0, 16'h0000, 20, 16'h03FE, 16'h4001, 0};
        steps[3]  = '{16'h0000, 1'b0, 16'h0000, L4, 16'h03FF, 16'h4001, 0};
        steps[4]  = '{16'h0000, 1'b1, 16'hC003, 2,  16'h03FF, 16'hC003, 0};
        steps[5]  = '{16'h0100, 1'b0, 16'h0000, L4, 16'h03FE, 16'hC003, 0};
        steps[6]  = '{16'h0101, 1'b0, 16'h0000, L4, 16'h03FC, 16'hC003, 1};
        steps[7]  = '{16'h0101, 1'b1, 16'hFFFF, 3,  16'h03FC, 16'hC3FF, 0};
        steps[8]  = '{16'h0FFF, 1'b0, 16'h0000, L4, 16'h0000, 16'hC3FF, 1};
        steps[9]  = '{16'hF000, 1'b0, 16'h0000, L4, 16'h03FF, 16'hC3FF, 0};
        steps[10] = '{16'h0000, 1'b1, 16'h4000, 2,  16'h03FF, 16'h4000, 0};
        steps[11] = '{16'h0C00, 1'b0, 16'h0000, L4, 16'h00FF, 16'h4000, 0};
        steps[12] = '{16'h0010, 1'b1, 16'h4040, L4, 16'h03BF, 16'h4040, 1};
        steps[13] = '{16'h0020, 1'b0, 16'h0000, L4, 16'h037F, 16'h4040, 0};
        steps[14] = '{16'h0004, 1'b0, 16'h0000, L4, 16'h03FB, 16'h4040, 0};
        steps[15] = '{16'h0008, 1'b0, 16'h0000, L4, 16'h03F7, 16'h4040, 0};
        steps[16] = '{16'h0080, 1'b0, 16'h0000, L4, 16'h03EF, 16'h4040, 0};
        steps[17] = '{16'h0040, 1'b0, 16'h0000, L4, 16'h03DF, 16'h4040, 0};
        steps[18] = '{16'h0400, 1'b0, 16'h0000, L4, 16'h01FF, 16'h4040, 0};
        steps[19] = '{16'h0800, 1'b0, 16'h0000, L4, 16'h02FF, 16'h4040, 0};
        steps[20] = '{16'h0202, 1'b0, 16'h0000, L4, 16'h03FF, 16'h4040, 0};
        steps[21] = '{16'h0010, 1'b0, 16'h0000, L4, 16'h03BF, 16'h4040, 1};

        reset        = 1'b1;
        buttons_raw  = 16'h0000;
        keycnt_we    = 1'b0;
        keycnt_wdata = 16'h0000;
        @(negedge clk);
        repeat (3) cyc();
        push_exp(16'h03FF, 16'h0000, 1'b0);
        compare_out("reset_hold");
        reset = 1'b0;
        cyc();
        push_exp(16'h03FF, 16'h0000, 1'b0);
        compare_out("after_reset");

        // Exact debounce latency and IRQ timing with OR mode on A.
        keycnt_we = 1'b1; keycnt_wdata = 16'h4001;
        cyc();
        keycnt_we = 1'b0;
        push_exp(16'h03FF, 16'h4001, 1'b0);
        compare_out("kc_write");
        buttons_raw = 16'h0100;
        repeat (LAT) cyc();
        push_exp(16'h03FF, 16'h4001, 1'b0);
        compare_out("lat_minus_one");
        cyc();
        push_exp(16'h03FE, 16'h4001, 1'b1);
        compare_out("lat_exact");
        cyc();
        push_exp(16'h03FE, 16'h4001, 1'b0);
        compare_out("irq_one_cycle");

        buttons_raw = 16'h0000;
        repeat (L4) cyc();
        push_exp(16'h03FF, 16'h4001, 1'b0);
        compare_out("release_a");

        // Short B glitch must be filtered out entirely.
        buttons_raw = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            cyc();
            push_exp(16'h03FF, 16'h4001, 1'b0);
            compare_out($sformatf("glitch_hi_%0d", i));
        end
        buttons_raw = 16'h0000;
        for (int i = 0; i < L4; i++) begin
            cyc();
            push_exp(16'h03FF, 16'h4001, 1'b0);
            compare_out($sformatf("glitch_lo_%0d", i));
        end

        // A second change while counting restarts the count.
        buttons_raw = 16'h0100;
        repeat (10) cyc();
        buttons_raw = 16'h0101;
        repeat (LAT) cyc();
        push_exp(16'h03FF, 16'h4001, 1'b0);
        compare_out("restart_before");
        cyc();
        push_exp(16'h03FC, 16'h4001, 1'b1);
        compare_out("restart_after");

        // A held, then enable: pulse in the cycle after the write edge.
        reset = 1'b1; buttons_raw = 16'h0100;
        repeat (2) cyc();
        push_exp(16'h03FF, 16'h0000, 1'b0);
        compare_out("reset2");
        reset = 1'b0;
        repeat (L4) cyc();
        push_exp(16'h03FE, 16'h0000, 1'b0);
        compare_out("held_no_en");
        keycnt_we = 1'b1; keycnt_wdata = 16'h4001;
        cyc();
        keycnt_we = 1'b0;
        push_exp(16'h03FE, 16'h4001, 1'b1);
        compare_out("en_pulse");
        cyc();
        push_exp(16'h03FE, 16'h4001, 1'b0);
        compare_out("en_pulse_end");

        // Reset in the middle of a debounce: no pulse afterwards without a KEYCNT write.
        buttons_raw = 16'h0000;
        repeat (L4) cyc();
        push_exp(16'h03FF, 16'h4001, 1'b0);
        compare_out("pre_mid_reset");
        buttons_raw = 16'h0100;
        repeat (8) cyc();
        reset = 1'b1;
        cyc();
        push_exp(16'h03FF, 16'h0000, 1'b0);
        compare_out("mid_reset");
        reset = 1'b0;
        irqs = 0;
        for (int i = 0; i < L4; i++) begin
            cyc();
            if (key_irq === 1'b1) irqs++;
        end
        check_int("mid_reset_irqs", irqs, 0);
        push_exp(16'h03FE, 16'h0000, 1'b0);
        compare_out("post_mid_reset");

        // Table-driven steps from a clean reset.
        reset = 1'b1; buttons_raw = 16'h0000;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        for (int s = 0; s < N_STEPS; s++) begin
            buttons_raw  = steps[s].btn;
            keycnt_we    = steps[s].we;
            keycnt_wdata = steps[s].wdata;
            push_exp(steps[s].exp_ki, steps[s].exp_kc, 1'b0);
            irqs = 0;
            for (int c = 0; c < steps[s].cycles; c++) begin
                cyc();
                keycnt_we = 1'b0;
                if (key_irq === 1'b1) irqs++;
            end
            compare_out($sformatf("step%0d", s));
            check_int($sformatf("step%0d_irqs", s), irqs, steps[s].exp_irqs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
